mem_stage: RTL and testbench

Pipeline MEM stage of the CPU, directly downstream of the execute stage. Consumes the EX/MEM register outputs, performs load/store accesses to the data cache over a request/ready handshake with byte-lane steering and load sign/zero extension, stalls the pipeline while an access is outstanding, and holds the MEM/WB pipeline register feeding write-back. A watchdog counter terminates accesses the cache never acknowledges.

---
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the MEM stage (master) and the data cache (slave).
// The master asserts cache_req_o and holds it, with address, data and enables stable, until it sees
// cache_ready_i high at a rising edge. That edge completes the access, and cache_rdata_i is used only on it.
interface mem_stage_if;
    logic        cache_req_o;
    logic        cache_we_o;
    logic [31:0] cache_addr_o;
    logic [31:0] cache_wdata_o;
    logic [3:0]  cache_be_o;
    logic        cache_ready_i;
    logic [31:0] cache_rdata_i;

    modport master (
        output cache_req_o, cache_we_o, cache_addr_o, cache_wdata_o, cache_be_o,
        input  cache_ready_i, cache_rdata_i
    );

    modport slave (
        input  cache_req_o, cache_we_o, cache_addr_o, cache_wdata_o, cache_be_o,
        output cache_ready_i, cache_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-cache load/store with lane steering, miss stall, watchdog and MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses and adds misalign_o.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] alu_mem_i,
    input  logic [31:0] rs2_mem_i,
    input  logic [31:0] pc4_mem_i,
    input  logic        MemRW_mem_i,
    input  logic [1:0]  WBSel_mem_i,
    input  logic        RegWEn_mem_i,
    input  logic [4:0]  rsW_mem_i,
    input  logic [31:0] inst_mem_i,
    input  logic        Valid_cpu2cache_mem_i,
    input  logic        flush_i,
    mem_stage_if.master cache,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic [31:0] alu_wb_o,
    output logic [31:0] ld_data_wb_o,
    output logic [31:0] pc4_wb_o,
    output logic [1:0]  WBSel_wb_o,
    output logic        RegWEn_wb_o,
    output logic [4:0]  rsW_wb_o,
    output logic [31:0] inst_wb_o,
    output logic        fsm_state_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] alu_wb_q, alu_wb_d;
    logic [31:0] ld_data_wb_q, ld_data_wb_d;
    logic [31:0] pc4_wb_q, pc4_wb_d;
    logic [1:0]  wbsel_wb_q, wbsel_wb_d;
    logic        regwen_wb_q, regwen_wb_d;
    logic [4:0]  rsw_wb_q, rsw_wb_d;
    logic [31:0] inst_wb_q, inst_wb_d;

    logic [2:0]  funct3;
    logic [1:0]  a_lo;
    logic        misaligned;
    logic        access;
    logic        timeout_hit;
    logic        timeout_done;
    logic        done;
    logic        bubble;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign funct3 = inst_mem_i[14:12];
    assign a_lo   = alu_mem_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign misaligned = Valid_cpu2cache_mem_i &
                        (((funct3[1:0] == 2'b01) && a_lo[0]) ||
                         ((funct3[1:0] == 2'b10) && (a_lo != 2'b00)));
    assign misalign_d = misaligned;
    assign misalign_o = misalign_q;
`else
    assign misaligned = 1'b0;
`endif

    // Counter holds the number of WAIT cycles already spent; the cycle that would bring it to TIMEOUT forces completion.
    assign access       = Valid_cpu2cache_mem_i & ~misaligned;
    assign timeout_hit  = (state_q == S_WAIT) && (({1'b0, cnt_q} + 9'd1) >= TO_LIM);
    assign timeout_done = timeout_hit & ~cache.cache_ready_i;
    assign done         = cache.cache_ready_i | timeout_hit;
    assign stall_o      = ~rst_i & access & ~done;
    assign bubble       = flush_i | flush_pend_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (access && !cache.cache_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wdata = rs2_mem_i;
        if (MemRW_mem_i) begin
            case (funct3[1:0])
                2'b00: begin
                    be    = 4'b0001 << a_lo;
                    wdata = {4{rs2_mem_i[7:0]}};
                end
                2'b01: begin
                    be    = 4'b0011 << {a_lo[1], 1'b0};
                    wdata = {2{rs2_mem_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_byte = cache.cache_rdata_i[7:0];
        case (a_lo)
            2'd1:    ld_byte = cache.cache_rdata_i[15:8];
            2'd2:    ld_byte = cache.cache_rdata_i[23:16];
            2'd3:    ld_byte = cache.cache_rdata_i[31:24];
            default: ;
        endcase
        ld_half  = a_lo[1] ? cache.cache_rdata_i[31:16] : cache.cache_rdata_i[15:0];
        load_ext = cache.cache_rdata_i;
        case (funct3)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'h0, ld_byte};
            3'b101:  load_ext = {16'h0, ld_half};
            default: ;
        endcase
    end

    // MEM/WB holds while stalled; a flushed instruction lands as an all-zero bubble.
    always_comb begin
        alu_wb_d     = alu_wb_q;
        ld_data_wb_d = ld_data_wb_q;
        pc4_wb_d     = pc4_wb_q;
        wbsel_wb_d   = wbsel_wb_q;
        regwen_wb_d  = regwen_wb_q;
        rsw_wb_d     = rsw_wb_q;
        inst_wb_d    = inst_wb_q;
        if (!stall_o) begin
            if (bubble) begin
                alu_wb_d     = 32'h0;
                ld_data_wb_d = 32'h0;
                pc4_wb_d     = 32'h0;
                wbsel_wb_d   = 2'b00;
                regwen_wb_d  = 1'b0;
                rsw_wb_d     = 5'd0;
                inst_wb_d    = 32'h0;
            end else begin
                alu_wb_d     = alu_mem_i;
                ld_data_wb_d = (access && !MemRW_mem_i && cache.cache_ready_i) ? load_ext : 32'h0;
                pc4_wb_d     = pc4_mem_i;
                wbsel_wb_d   = WBSel_mem_i;
                regwen_wb_d  = RegWEn_mem_i & ~timeout_done & ~misaligned;
                rsw_wb_d     = rsW_mem_i;
                inst_wb_d    = inst_mem_i;
            end
        end
    end

    assign flush_pend_d = stall_o & (flush_pend_q | flush_i);
    assign bus_err_d    = timeout_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            flush_pend_q <= 1'b0;
            bus_err_q    <= 1'b0;
            alu_wb_q     <= 32'h0;
            ld_data_wb_q <= 32'h0;
            pc4_wb_q     <= 32'h0;
            wbsel_wb_q   <= 2'b00;
            regwen_wb_q  <= 1'b0;
            rsw_wb_q     <= 5'd0;
            inst_wb_q    <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            bus_err_q    <= bus_err_d;
            alu_wb_q     <= alu_wb_d;
            ld_data_wb_q <= ld_data_wb_d;
            pc4_wb_q     <= pc4_wb_d;
            wbsel_wb_q   <= wbsel_wb_d;
            regwen_wb_q  <= regwen_wb_d;
            rsw_wb_q     <= rsw_wb_d;
            inst_wb_q    <= inst_wb_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign cache.cache_req_o   = ~rst_i & ((state_q == S_WAIT) | access);
    assign cache.cache_we_o    = MemRW_mem_i;
    assign cache.cache_addr_o  = {alu_mem_i[31:2], 2'b00};
    assign cache.cache_wdata_o = wdata;
    assign cache.cache_be_o    = be;

    assign bus_err_o    = bus_err_q;
    assign alu_wb_o     = alu_wb_q;
    assign ld_data_wb_o = ld_data_wb_q;
    assign pc4_wb_o     = pc4_wb_q;
    assign WBSel_wb_o   = wbsel_wb_q;
    assign RegWEn_wb_o  = regwen_wb_q;
    assign rsW_wb_o     = rsw_wb_q;
    assign inst_wb_o    = inst_wb_q;
    assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, hand sequences for reset/timeout, and random ops vs a reference model.
// Honours MEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_stage;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] addr, wd, pc4, inst, rdata;
        logic        st, valid, regwen;
        logic [1:0]  wbsel;
        logic [4:0]  rsw;
        int          delay, flush_cyc;
    } op_t;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] wdata, ld;
        int          stalls;
        logic        regwen, err, mis, flushed;
    } exp_t;

    typedef struct {
        string tag;
        op_t   op;
        exp_t  e;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] alu_mem_i = '0, rs2_mem_i = '0, pc4_mem_i = '0, inst_mem_i = '0;
    logic        MemRW_mem_i = 1'b0, RegWEn_mem_i = 1'b0, Valid_cpu2cache_mem_i = 1'b0, flush_i = 1'b0;
    logic [1:0]  WBSel_mem_i = '0;
    logic [4:0]  rsW_mem_i = '0;
    logic        stall_o, bus_err_o, RegWEn_wb_o, fsm_state_o;
    logic [31:0] alu_wb_o, ld_data_wb_o, pc4_wb_o, inst_wb_o;
    logic [1:0]  WBSel_wb_o;
    logic [4:0]  rsW_wb_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[$];

    mem_stage_if cif();

    always #5 clk_i = ~clk_i;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_mem_i(alu_mem_i), .rs2_mem_i(rs2_mem_i), .pc4_mem_i(pc4_mem_i),
        .MemRW_mem_i(MemRW_mem_i), .WBSel_mem_i(WBSel_mem_i), .RegWEn_mem_i(RegWEn_mem_i),
        .rsW_mem_i(rsW_mem_i), .inst_mem_i(inst_mem_i),
        .Valid_cpu2cache_mem_i(Valid_cpu2cache_mem_i), .flush_i(flush_i),
        .cache(cif.master),
        .stall_o(stall_o), .bus_err_o(bus_err_o),
        .alu_wb_o(alu_wb_o), .ld_data_wb_o(ld_data_wb_o), .pc4_wb_o(pc4_wb_o),
        .WBSel_wb_o(WBSel_wb_o), .RegWEn_wb_o(RegWEn_wb_o), .rsW_wb_o(rsW_wb_o),
        .inst_wb_o(inst_wb_o), .fsm_state_o(fsm_state_o)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] addr, input logic [31:0] wd, input logic st,
                                  input logic [2:0] f3, input logic valid, input logic regwen,
                                  input int delay, input logic [31:0] rdata, input int fc);
        op_t o;
        logic [31:0] ins;
        ins = $urandom();
        ins[14:12] = f3;
        o.addr = addr; o.wd = wd; o.st = st; o.inst = ins; o.valid = valid; o.regwen = regwen;
        o.delay = delay; o.rdata = rdata; o.flush_cyc = fc;
        o.pc4 = $urandom();
        o.wbsel = 2'($urandom_range(0, 3));
        o.rsw = 5'($urandom_range(1, 31));
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] ld,
                                    input int stalls, input logic regwen, input logic err,
                                    input logic flushed, input logic mis);
        exp_t e;
        e.be = be; e.wdata = wdata; e.ld = ld; e.stalls = stalls;
        e.regwen = regwen; e.err = err; e.flushed = flushed; e.mis = mis;
        return e;
    endfunction

    // Reference model: access size/offset arithmetic, latency = min(ready delay, TO).
    function automatic exp_t model(input op_t o);
        exp_t e;
        logic [2:0] f3;
        int bytes, off;
        logic [31:0] mask, v;
        f3 = o.inst[14:12];
        bytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = (bytes == 1) ? int'(o.addr[1:0]) : (bytes == 2) ? 2 * int'(o.addr[1]) : 0;
        e.mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        e.mis = o.valid && ((bytes == 2 && o.addr[0]) || (bytes == 4 && o.addr[1:0] != 2'b00));
`endif
        e.err = o.valid && !e.mis && (o.delay > TO);
        e.stalls = (!o.valid || e.mis) ? 0 : (e.err ? TO : o.delay);
        e.flushed = (o.flush_cyc >= 0) && (o.flush_cyc <= e.stalls);
        e.be = 4'hF;
        e.wdata = o.wd;
        if (o.st) begin
            e.be = 4'(((1 << bytes) - 1) << off);
            e.wdata = (bytes == 1) ? o.wd[7:0] * 32'h0101_0101 :
                      (bytes == 2) ? o.wd[15:0] * 32'h0001_0001 : o.wd;
        end
        mask = (bytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * bytes)) - 32'h1;
        v = (o.rdata >> (8 * off)) & mask;
        if (!f3[2] && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
        e.ld = (o.valid && !o.st && !e.mis && !e.err && !e.flushed) ? v : 32'h0;
        e.regwen = (e.flushed || e.err || e.mis) ? 1'b0 : o.regwen;
        return e;
    endfunction

    // Drives one EX/MEM instruction from a negedge and follows it until MEM/WB is written.
    task automatic run_op(input op_t o, input exp_t e, input string tag);
        int c;
        int stalls;
        logic done;
        alu_mem_i = o.addr; rs2_mem_i = o.wd; pc4_mem_i = o.pc4; inst_mem_i = o.inst;
        MemRW_mem_i = o.st; WBSel_mem_i = o.wbsel; RegWEn_mem_i = o.regwen; rsW_mem_i = o.rsw;
        Valid_cpu2cache_mem_i = o.valid;
        flush_i = (o.flush_cyc == 0);
        cif.cache_ready_i = o.valid && (o.delay == 0);
        cif.cache_rdata_i = (o.delay == 0) ? o.rdata : $urandom();
        exp_q.push_back(e.ld);
        c = 0;
        stalls = 0;
        forever begin
            #1;
            if (c == 0) begin
                chk({tag, " req"}, 32'(cif.cache_req_o), 32'(o.valid && !e.mis));
                if (o.valid && !e.mis) begin
                    chk({tag, " addr"}, cif.cache_addr_o, o.addr & 32'hFFFF_FFFC);
                    chk({tag, " we"}, 32'(cif.cache_we_o), 32'(o.st));
                    chk({tag, " be"}, 32'(cif.cache_be_o), 32'(e.be));
                    if (o.st) chk({tag, " wdata"}, cif.cache_wdata_o, e.wdata);
                end
            end else begin
                chk({tag, " req_held"}, 32'(cif.cache_req_o), 32'd1);
            end
            done = !stall_o;
            if (!done) stalls++;
            @(posedge clk_i);
            @(negedge clk_i);
            if (done || c >= 300) break;
            c++;
            flush_i = (c == o.flush_cyc);
            cif.cache_ready_i = (c == o.delay);
            cif.cache_rdata_i = (c == o.delay) ? o.rdata : $urandom();
        end
        Valid_cpu2cache_mem_i = 1'b0;
        flush_i = 1'b0;
        cif.cache_ready_i = 1'b0;
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(e.stalls));
        chk({tag, " ld_data"}, ld_data_wb_o, exp_q.pop_front());
        chk({tag, " regwen"}, 32'(RegWEn_wb_o), 32'(e.regwen));
        chk({tag, " alu_wb"}, alu_wb_o, e.flushed ? 32'h0 : o.addr);
        chk({tag, " pc4_wb"}, pc4_wb_o, e.flushed ? 32'h0 : o.pc4);
        chk({tag, " inst_wb"}, inst_wb_o, e.flushed ? 32'h0 : o.inst);
        chk({tag, " rsw_wb"}, 32'(rsW_wb_o), e.flushed ? 32'h0 : 32'(o.rsw));
        chk({tag, " wbsel_wb"}, 32'(WBSel_wb_o), e.flushed ? 32'h0 : 32'(o.wbsel));
        chk({tag, " bus_err"}, 32'(bus_err_o), 32'(e.err));
`ifdef MEM_MISALIGN_TRAP_EN
        chk({tag, " misalign"}, 32'(misalign_o), 32'(e.mis));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        exp_t e;
        cif.cache_ready_i = 1'b0;
        cif.cache_rdata_i = 32'h0;

        // Reset: request suppressed, MEM/WB and status cleared.
        repeat (2) @(negedge clk_i);
        alu_mem_i = 32'h1000; inst_mem_i = 32'h0000_2003; RegWEn_mem_i = 1'b1;
        Valid_cpu2cache_mem_i = 1'b1;
        #1;
        chk("reset req", 32'(cif.cache_req_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("reset alu_wb", alu_wb_o, 32'h0);
        chk("reset regwen", 32'(RegWEn_wb_o), 32'd0);
        chk("reset inst_wb", inst_wb_o, 32'h0);
        chk("reset bus_err", 32'(bus_err_o), 32'd0);
        chk("reset fsm", 32'(fsm_state_o), 32'd0);
        Valid_cpu2cache_mem_i = 1'b0;
        rst_i = 1'b0;

        vecs.push_back('{"lb_hit", mk_op(32'h1003, 32'h0, 0, 3'b000, 1, 1, 0, 32'h80AA_BBCC, -1),
                         mk_exp(4'hF, 32'h0, 32'hFFFF_FF80, 0, 1, 0, 0, 0)});
        vecs.push_back('{"sh", mk_op(32'h2002, 32'h1234_ABCD, 1, 3'b001, 1, 0, 0, 32'h0, -1),
                         mk_exp(4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"lw_miss3", mk_op(32'h3000, 32'h0, 0, 3'b010, 1, 1, 3, 32'hDEAD_BEEF, -1),
                         mk_exp(4'hF, 32'h0, 32'hDEAD_BEEF, 3, 1, 0, 0, 0)});
        vecs.push_back('{"lbu", mk_op(32'h1001, 32'h0, 0, 3'b100, 1, 1, 0, 32'h0000_F600, -1),
                         mk_exp(4'hF, 32'h0, 32'h0000_00F6, 0, 1, 0, 0, 0)});
        vecs.push_back('{"lh", mk_op(32'h1002, 32'h0, 0, 3'b001, 1, 1, 0, 32'h8001_0000, -1),
                         mk_exp(4'hF, 32'h0, 32'hFFFF_8001, 0, 1, 0, 0, 0)});
        vecs.push_back('{"lhu", mk_op(32'h1002, 32'h0, 0, 3'b101, 1, 1, 0, 32'h8001_0000, -1),
                         mk_exp(4'hF, 32'h0, 32'h0000_8001, 0, 1, 0, 0, 0)});
        vecs.push_back('{"sb", mk_op(32'h0041, 32'h0000_00A5, 1, 3'b000, 1, 0, 0, 32'h0, -1),
                         mk_exp(4'b0010, 32'hA5A5_A5A5, 32'h0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"sw", mk_op(32'h0040, 32'h1122_3344, 1, 3'b010, 1, 0, 1, 32'h0, -1),
                         mk_exp(4'hF, 32'h1122_3344, 32'h0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"alu_pass", mk_op(32'h0055, 32'h0, 0, 3'b001, 0, 1, 0, 32'h0, -1),
                         mk_exp(4'hF, 32'h0, 32'h0, 0, 1, 0, 0, 0)});
`ifdef MEM_MISALIGN_TRAP_EN
        vecs.push_back('{"lw_misalign", mk_op(32'h1001, 32'h0, 0, 3'b010, 1, 1, 0, 32'hCAFE_F00D, -1),
                         mk_exp(4'hF, 32'h0, 32'h0, 0, 0, 0, 0, 1)});
`else
        vecs.push_back('{"lw_misalign", mk_op(32'h1001, 32'h0, 0, 3'b010, 1, 1, 0, 32'hCAFE_F00D, -1),
                         mk_exp(4'hF, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 0, 0)});
`endif
        vecs.push_back('{"flush_wait", mk_op(32'h3008, 32'h0, 0, 3'b010, 1, 1, 3, 32'h1234_5678, 1),
                         mk_exp(4'hF, 32'h0, 32'h0, 3, 0, 0, 1, 0)});
        vecs.push_back('{"flush_hit", mk_op(32'h3009, 32'h0, 0, 3'b000, 1, 1, 0, 32'h1234_5678, 0),
                         mk_exp(4'hF, 32'h0, 32'h0, 0, 0, 0, 1, 0)});
        vecs.push_back('{"lb_miss2", mk_op(32'h1002, 32'h0, 0, 3'b000, 1, 1, 2, 32'h00FF_0000, -1),
                         mk_exp(4'hF, 32'h0, 32'hFFFF_FFFF, 2, 1, 0, 0, 0)});
        vecs.push_back('{"ready_at_limit", mk_op(32'h300C, 32'h0, 0, 3'b010, 1, 1, TO, 32'h0BAD_F00D, -1),
                         mk_exp(4'hF, 32'h0, 32'h0BAD_F00D, TO, 1, 0, 0, 0)});
        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].e, vecs[i].tag);

        // Timeout: one bus_err pulse, RegWEn dropped, FSM back to IDLE.
        run_op(mk_op(32'h3004, 32'h0, 0, 3'b010, 1, 1, 50, 32'h1234_5678, -1),
               mk_exp(4'hF, 32'h0, 32'h0, TO, 0, 1, 0, 0), "timeout");
        chk("timeout fsm_idle", 32'(fsm_state_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("timeout bus_err_once", 32'(bus_err_o), 32'd0);

        // Reset in the middle of a WAIT abandons the access.
        alu_mem_i = 32'h5000; inst_mem_i = 32'h0000_2003; MemRW_mem_i = 1'b0;
        Valid_cpu2cache_mem_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midwait fsm_wait", 32'(fsm_state_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("midwait req_in_reset", 32'(cif.cache_req_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midwait fsm_idle", 32'(fsm_state_o), 32'd0);
        chk("midwait alu_wb", alu_wb_o, 32'h0);
        Valid_cpu2cache_mem_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            logic [2:0] f3;
            logic st, valid;
            int k, delay, fc;
            valid = ($urandom_range(0, 9) < 7);
            st = valid && ($urandom_range(0, 1) == 1);
            k = $urandom_range(0, 4);
            f3 = st ? 3'($urandom_range(0, 2)) : 3'((k < 3) ? k : k + 1);
            delay = (!valid || $urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, TO + 2);
            fc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            o = mk_op($urandom(), $urandom(), st, f3, valid, 1'($urandom_range(0, 1)), delay, $urandom(), fc);
            e = model(o);
            run_op(o, e, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
